mii_uart_bridge: RTL and testbench

//   Multi-channel successor to the single-port MII-to-serial path. Captures completed bytes

---
 rtl/mii_uart_bridge.sv | 180 ++++++++++++++++++
 tb/tb_mii_uart_bridge.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mii_uart_bridge.sv
// Multi-channel MII byte capture into per-channel FIFOs, drained round-robin into one uart_tx.
// Define MII_UART_HEX_EN to emit each byte as a 3-character record: channel tag, hex high, hex low.
module mii_uart_bridge #(
    parameter int CHANNELS   = 2,
    parameter int DEPTH_LOG2 = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in_rdy,
    input  logic [8*CHANNELS-1:0] in_q,
    input  logic                  tx_active,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    output logic [CHANNELS-1:0]   ovf,
    output logic                  busy
);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t               state;
    logic [CW-1:0]        grant;
    logic [CW-1:0]        last_grant;
    logic [CW-1:0]        next_grant;
    logic                 grant_ok;

    logic [CHANNELS-1:0]  s1, s2, s3;
    logic [CHANNELS-1:0]  wr;
    logic [CHANNELS-1:0]  empty;
    logic [CHANNELS-1:0]  full;
    logic [DEPTH_LOG2:0]  wp [CHANNELS];
    logic [DEPTH_LOG2:0]  rp [CHANNELS];
    logic [7:0]           mem [CHANNELS][DEPTH];
    logic [7:0]           rd_data;

`ifdef MII_UART_HEX_EN
    logic [7:0]           rec_byte;
    logic [1:0]           char_idx;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    // One write per rising edge of the synchronised ready level.
    assign wr = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_rdy;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            empty[c] = (wp[c] == rp[c]);
            full[c]  = (wp[c][DEPTH_LOG2] != rp[c][DEPTH_LOG2]) &&
                       (wp[c][DEPTH_LOG2-1:0] == rp[c][DEPTH_LOG2-1:0]);
        end
    end

    // Full is from registered pointers, so a same-cycle pop never rescues a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wp[c] <= '0;
                rp[c] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (wr[c]) begin
                    if (full[c])
                        ovf[c] <= 1'b1;
                    else
                        wp[c] <= wp[c] + 1'b1;
                end
                if (state == LOAD && grant == CW'(c))
                    rp[c] <= rp[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (wr[c] && !full[c])
                mem[c][wp[c][DEPTH_LOG2-1:0]] <= in_q[8*c +: 8];
        end
    end

    assign rd_data = mem[grant][rp[grant][DEPTH_LOG2-1:0]];

    always_comb begin
        grant_ok   = 1'b0;
        next_grant = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            int unsigned k;
            k = (32'(last_grant) + i) % CHANNELS;
            if (!grant_ok && !empty[k]) begin
                grant_ok   = 1'b1;
                next_grant = CW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CW'(CHANNELS - 1);
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
`ifdef MII_UART_HEX_EN
            rec_byte   <= '0;
            char_idx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!tx_active && grant_ok) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
`ifdef MII_UART_HEX_EN
                    tx_byte  <= 8'h30 + 8'(grant);
                    rec_byte <= rd_data;
                    char_idx <= 2'd1;
`else
                    tx_byte  <= rd_data;
`endif
                    tx_dv    <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    tx_dv <= 1'b0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_active)
                        state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_active) begin
`ifdef MII_UART_HEX_EN
                        if (char_idx == 2'd1) begin
                            tx_byte  <= hex_digit(rec_byte[7:4]);
                            tx_dv    <= 1'b1;
                            char_idx <= 2'd2;
                            state    <= SEND;
                        end else if (char_idx == 2'd2) begin
                            tx_byte  <= hex_digit(rec_byte[3:0]);
                            tx_dv    <= 1'b1;
                            char_idx <= 2'd3;
                            state    <= SEND;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (|(~empty));

endmodule

// File: tb/tb_mii_uart_bridge.sv
// Directed bench for mii_uart_bridge with a small uart_tx model that logs every started character.
module tb_mii_uart_bridge;
    localparam int CH = 2;
    localparam int DL = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [CH-1:0]   in_rdy = '0;
    logic [8*CH-1:0] in_q = '0;
    logic            tx_active;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic [CH-1:0]   ovf;
    logic            busy;

    int              total = 0;
    int              bad = 0;
    logic            hold = 1'b0;
    int              bcnt = 0;
    logic [7:0]      log_q[$];
    logic [7:0]      exp_q[$];

    mii_uart_bridge #(.CHANNELS(CH), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .in_rdy(in_rdy), .in_q(in_q),
        .tx_active(tx_active), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for 6 cycles after each start pulse
    assign tx_active = hold || (bcnt != 0);
    always @(negedge clk) begin
        if (tx_dv) begin
            log_q.push_back(tx_byte);
            bcnt <= 6;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    task automatic expect_byte(input int ch, input logic [7:0] b);
`ifdef MII_UART_HEX_EN
        exp_q.push_back(8'h30 + 8'(ch));
        exp_q.push_back(hx(b[7:4]));
        exp_q.push_back(hx(b[3:0]));
`else
        exp_q.push_back(b);
`endif
    endtask

    task automatic cmp_log(input string tag);
        int mism = 0;
        chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) mism++;
        chk({tag, "_data"}, 32'(mism), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        in_rdy = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        exp_q.delete();
        chk({tag, "_rst_dv"}, 32'(tx_dv), 32'd0);
        chk({tag, "_rst_byte"}, 32'(tx_byte), 32'd0);
        chk({tag, "_rst_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic push(input int ch, input logic [7:0] b);
        @(negedge clk);
        in_q[8*ch +: 8] = b;
        in_rdy[ch] = 1'b1;
        repeat (3) @(negedge clk);
        in_rdy[ch] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        repeat (4) @(negedge clk);
        while ((busy || tx_active) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < max), 32'd1);
    endtask

    initial begin
        int n;
        int n0;

        // 1: single byte, latency to start pulse
        do_reset("t1");
        expect_byte(0, 8'h5A);
        @(negedge clk);
        in_q[7:0] = 8'h5A;
        in_rdy[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("t1_dv_e3", 32'(tx_dv), 32'd0);
        @(negedge clk);
        chk("t1_dv_e4", 32'(tx_dv), 32'd1);
        chk("t1_byte_e4", 32'(tx_byte), 32'(exp_q[0]));
        @(negedge clk);
        chk("t1_dv_e5", 32'(tx_dv), 32'd0);
        in_rdy[0] = 1'b0;
        wait_idle("t1", 200);
        chk("t1_busy", 32'(busy), 32'd0);
        cmp_log("t1");

        // 2: held ready level writes once
        do_reset("t2");
        @(negedge clk);
        in_q[7:0] = 8'h3C;
        in_rdy[0] = 1'b1;
        repeat (20) @(negedge clk);
        in_rdy[0] = 1'b0;
        wait_idle("t2", 200);
        expect_byte(0, 8'h3C);
        cmp_log("t2");

        // 3: simultaneous writes, round-robin order
        do_reset("t3");
        @(negedge clk);
        in_q = {8'h22, 8'h11};
        in_rdy = 2'b11;
        repeat (3) @(negedge clk);
        in_rdy = 2'b00;
        repeat (3) @(negedge clk);
        in_q[7:0] = 8'h33;
        in_rdy[0] = 1'b1;
        repeat (3) @(negedge clk);
        in_rdy[0] = 1'b0;
        wait_idle("t3", 300);
        expect_byte(0, 8'h11);
        expect_byte(1, 8'h22);
        expect_byte(0, 8'h33);
        cmp_log("t3");

        // 4: overflow on ch1 while uart is held busy
        do_reset("t4");
        hold = 1'b1;
        for (int k = 1; k <= 129; k++)
            push(1, 8'(k));
        repeat (4) @(negedge clk);
        chk("t4_ovf", 32'(ovf), 32'h2);
        chk("t4_nostart", 32'(log_q.size()), 32'd0);
        hold = 1'b0;
        wait_idle("t4", 10000);
        for (int k = 1; k <= 128; k++)
            expect_byte(1, 8'(k));
        cmp_log("t4");
        if (log_q.size() > 0)
            chk("t4_last", 32'(log_q[log_q.size()-1]), 32'(exp_q[exp_q.size()-1]));
        else
            chk("t4_last", 32'hFFFF_FFFF, 32'(exp_q[exp_q.size()-1]));
        chk("t4_ovf_kept", 32'(ovf), 32'h2);

`ifdef MII_UART_HEX_EN
        // 5: hex record for 0xA7 on ch1
        do_reset("t5");
        push(1, 8'hA7);
        wait_idle("t5", 300);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h37);
        cmp_log("t5");
`endif

        // 6: reset while waiting for uart to go idle
        do_reset("t6");
        @(negedge clk);
        in_q[7:0] = 8'h5A;
        in_rdy[0] = 1'b1;
        n = 0;
        while (!tx_dv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_start_timeout", 32'(n < 20), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        in_rdy = '0;
        @(negedge clk);
        chk("t6_dv", 32'(tx_dv), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        n0 = log_q.size();
        repeat (15) @(negedge clk);
        chk("t6_nopulse", 32'(log_q.size()), 32'(n0));
        log_q.delete();
        exp_q.delete();
        push(1, 8'hC3);
        wait_idle("t6", 300);
        expect_byte(1, 8'hC3);
        cmp_log("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
